// File: rtl/deserializer_flat.sv
// Purpose: collects N_SAMPLES serial words of BIT_WIDTH bits into one packed frame.
// Latency: the frame is offered (send_val) the cycle after its last word is accepted.
// Backpressure: recv_rdy stays low while a frame waits; the frame is held until send_rdy.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   recv_msg/recv_val/recv_rdy  serial word input (valid/ready)
//   send_msg/send_val/send_rdy  packed frame output; word i at [BIT_WIDTH*i +: BIT_WIDTH]
module deserializer_flat #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [BIT_WIDTH-1:0]           recv_msg,
  input  logic                           recv_val,
  output logic                           recv_rdy,
  output logic [BIT_WIDTH*N_SAMPLES-1:0] send_msg,
  output logic                           send_val,
  input  logic                           send_rdy
);

  localparam int CW = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

  localparam logic ST_RECV = 1'b0;
  localparam logic ST_SEND = 1'b1;

  logic                           state_q, state_d;
  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [BIT_WIDTH*N_SAMPLES-1:0] slots_q, slots_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    slots_d  = slots_q;
    recv_rdy = (state_q == ST_RECV);
    send_val = (state_q == ST_SEND);

    if (state_q == ST_RECV) begin
      if (recv_val) begin
        // Decode the slot index explicitly rather than a variable part-select.
        for (int i = 0; i < N_SAMPLES; i++) begin
          if (cnt_q == CW'(i)) begin
            slots_d[BIT_WIDTH*i +: BIT_WIDTH] = recv_msg;
          end
        end
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end else begin
      if (send_rdy) begin
        state_d = ST_RECV;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RECV;
      cnt_q   <= '0;
      slots_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slots_q <= slots_d;
    end
  end

  // Frame comes straight from the slot registers; no path from recv_msg.
  assign send_msg = slots_q;

endmodule
